// File: rtl/display7_pkg.sv
// Shared types and constants for the seven-segment display controller.
package display7_pkg;

    typedef enum logic [1:0] {
        MODE_HEX  = 2'd0,
        MODE_UDEC = 2'd1,
        MODE_SDEC = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        COMMIT
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    function automatic int bcd_digits(input int w);
        return (w * 3) / 10 + 1;
    endfunction

endpackage

// File: rtl/display7_controller_glyph.sv
// Active-low 4-bit to seven-segment glyph decoder (bit 0 = a, bit 6 = g).
module seg7_glyph (
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'h7F;
        unique case (digit)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
    end

endmodule

// File: rtl/display7_controller.sv
// Seven-segment display controller: hex, unsigned and signed decimal via
// sequential double-dabble, with leading-zero blanking and overflow flag.
module display7_controller
    import display7_pkg::*;
#(
    parameter int N_DIGITS = 6,
    parameter int DATA_W   = 32
) (
    input  logic                  iCLK,
    input  logic                  iRST_n,
    input  logic [DATA_W-1:0]     iData,
    input  logic                  iLoad,
    input  logic [1:0]            iMode,
    input  logic                  iBlank_lz,
    output logic [7*N_DIGITS-1:0] oHEX,
    output logic                  oBusy,
    output logic                  oDone,
    output logic                  oOvf
);

    localparam int BCD_DIGITS = bcd_digits(DATA_W);
    localparam int BCD_W      = 4 * BCD_DIGITS;
    localparam int HEX_DIGITS = (DATA_W + 3) / 4;
    localparam int NSRC_A     = (HEX_DIGITS > BCD_DIGITS) ? HEX_DIGITS : BCD_DIGITS;
    localparam int NSRC       = (NSRC_A > N_DIGITS) ? NSRC_A : N_DIGITS;
    localparam int CNT_W      = $clog2(DATA_W + 1);

    state_e               state, next_state;
    mode_e                mode_q, load_mode;
    logic                 blank_q, neg_q, load_neg;
    logic [DATA_W-1:0]    data_q, load_mag;
    logic [BCD_W-1:0]     bcd_q, bcd_adj;
    logic [CNT_W-1:0]     cnt_q;
    logic [7*N_DIGITS-1:0] hex_q, next_hex;
    logic                 ovf_q, next_ovf, done_q;
    logic [4*NSRC-1:0]    src_pad;
    int                   n_src, n_use;
    logic [6:0]           glyph [N_DIGITS];

    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        for (int i = 0; i < BCD_DIGITS; i++)
            r[4*i +: 4] = (v[4*i +: 4] >= 4'd5) ? v[4*i +: 4] + 4'd3 : v[4*i +: 4];
        return r;
    endfunction

    always_comb begin
        unique case (iMode)
            2'd1:    load_mode = MODE_UDEC;
            2'd2:    load_mode = MODE_SDEC;
            default: load_mode = MODE_HEX;
        endcase
        load_neg = (load_mode == MODE_SDEC) && iData[DATA_W-1];
        load_mag = load_neg ? (~iData + DATA_W'(1)) : iData;
    end

    assign bcd_adj = add3(bcd_q);

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) state <= IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (iLoad) next_state = (load_mode == MODE_HEX) ? COMMIT : CONV;
            CONV:    if (cnt_q == CNT_W'(DATA_W - 1)) next_state = COMMIT;
            COMMIT:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            mode_q  <= MODE_HEX;
            blank_q <= 1'b0;
            neg_q   <= 1'b0;
            data_q  <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            hex_q   <= {N_DIGITS{SEG_BLANK}};
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: if (iLoad) begin
                    data_q  <= load_mag;
                    mode_q  <= load_mode;
                    blank_q <= iBlank_lz;
                    neg_q   <= load_neg;
                    bcd_q   <= '0;
                    cnt_q   <= '0;
                end
                CONV: begin
                    bcd_q  <= {bcd_adj[BCD_W-2:0], data_q[DATA_W-1]};
                    data_q <= data_q << 1;
                    cnt_q  <= cnt_q + CNT_W'(1);
                end
                COMMIT: begin
                    hex_q  <= next_hex;
                    ovf_q  <= next_ovf;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Source digits, zero-padded so every index below NSRC is in range.
    always_comb begin
        src_pad = '0;
        if (mode_q == MODE_HEX) src_pad[DATA_W-1:0] = data_q;
        else                    src_pad[BCD_W-1:0]  = bcd_q;
        n_src = (mode_q == MODE_HEX) ? HEX_DIGITS : BCD_DIGITS;
        n_use = neg_q ? N_DIGITS - 1 : N_DIGITS;
        next_ovf = 1'b0;
        for (int i = 0; i < NSRC; i++)
            if (i >= n_use && src_pad[4*i +: 4] != 4'd0) next_ovf = 1'b1;
    end

    for (genvar k = 0; k < N_DIGITS; k++) begin : g_glyph
        seg7_glyph u_glyph (
            .digit (src_pad[4*k +: 4]),
            .seg   (glyph[k])
        );
    end

    always_comb begin
        logic lead;
        lead     = blank_q;
        next_hex = '0;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            if (neg_q && k == N_DIGITS - 1) begin
                next_hex[7*k +: 7] = SEG_MINUS;
            end else if (k >= n_src) begin
                next_hex[7*k +: 7] = SEG_BLANK;
            end else begin
                if (src_pad[4*k +: 4] != 4'd0 || k == 0) lead = 1'b0;
                next_hex[7*k +: 7] = lead ? SEG_BLANK : glyph[k];
            end
        end
    end

    assign oHEX  = hex_q;
    assign oBusy = (state != IDLE);
    assign oDone = done_q;
    assign oOvf  = ovf_q;

endmodule

// File: tb/tb_display7_controller.sv
// Directed testbench for display7_controller (N_DIGITS=6, DATA_W=32).
module tb_display7_controller;

    localparam int N = 6;
    localparam int W = 32;

    localparam logic [6:0] G0 = 7'h40, G1 = 7'h79, G2 = 7'h24, G3 = 7'h30;
    localparam logic [6:0] G4 = 7'h19, G5 = 7'h12, G6 = 7'h02, G7 = 7'h78;
    localparam logic [6:0] G8 = 7'h00, GA = 7'h08, GB = 7'h03;
    localparam logic [6:0] GC = 7'h46, GD = 7'h21, GE = 7'h06, GF = 7'h0E;
    localparam logic [6:0] BL = 7'h7F, MI = 7'h3F;

    logic           iCLK = 1'b0;
    logic           iRST_n;
    logic [W-1:0]   iData;
    logic           iLoad;
    logic [1:0]     iMode;
    logic           iBlank_lz;
    logic [7*N-1:0] oHEX;
    logic           oBusy, oDone, oOvf;

    int checks = 0;
    int errors = 0;

    display7_controller #(.N_DIGITS(N), .DATA_W(W)) dut (
        .iCLK      (iCLK),
        .iRST_n    (iRST_n),
        .iData     (iData),
        .iLoad     (iLoad),
        .iMode     (iMode),
        .iBlank_lz (iBlank_lz),
        .oHEX      (oHEX),
        .oBusy     (oBusy),
        .oDone     (oDone),
        .oOvf      (oOvf)
    );

    always #5 iCLK = ~iCLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run(input logic [W-1:0] d, input logic [1:0] m, input logic b,
                       input int lat, input logic [7*N-1:0] exp_hex,
                       input logic exp_ovf, input string tag);
        int n;
        n = 0;
        @(negedge iCLK);
        iData = d; iMode = m; iBlank_lz = b; iLoad = 1'b1;
        @(negedge iCLK);
        iLoad = 1'b0;
        while (oDone !== 1'b1 && n < 100) begin
            n++;
            @(negedge iCLK);
        end
        check({tag, "_lat"}, 64'(n), 64'(lat));
        check({tag, "_busy"}, 64'(oBusy), 64'(0));
        check({tag, "_hex"}, 64'(oHEX), 64'(exp_hex));
        check({tag, "_ovf"}, 64'(oOvf), 64'(exp_ovf));
    endtask

    initial begin
        int dones;
        iRST_n = 1'b0; iData = '0; iLoad = 1'b0; iMode = 2'd0; iBlank_lz = 1'b0;
        repeat (3) @(negedge iCLK);
        check("rst_hex", 64'(oHEX), 64'h3FF_FFFF_FFFF);
        check("rst_busy", 64'(oBusy), 64'(0));
        check("rst_done", 64'(oDone), 64'(0));
        check("rst_ovf", 64'(oOvf), 64'(0));
        iRST_n = 1'b1;

        run(32'h00ABCDEF, 2'd0, 1'b0, 1, {GA, GB, GC, GD, GE, GF}, 1'b0, "hex_abcdef");
        run(32'h12345678, 2'd0, 1'b0, 1, {G3, G4, G5, G6, G7, G8}, 1'b1, "hex_ovf");
        run(32'h000000A0, 2'd0, 1'b1, 1, {BL, BL, BL, BL, GA, G0}, 1'b0, "hex_blank");
        run(32'h00123456, 2'd3, 1'b0, 1, {G1, G2, G3, G4, G5, G6}, 1'b0, "mode3_hex");
        run(32'd123456, 2'd1, 1'b0, 33, {G1, G2, G3, G4, G5, G6}, 1'b0, "udec");
        run(32'd1234567, 2'd1, 1'b0, 33, {G2, G3, G4, G5, G6, G7}, 1'b1, "udec_ovf");
        run(32'hFFFFFFD6, 2'd2, 1'b1, 33, {MI, BL, BL, BL, G4, G2}, 1'b0, "sdec_m42");
        run(32'd42, 2'd2, 1'b0, 33, {G0, G0, G0, G0, G4, G2}, 1'b0, "sdec_p42");
        run(32'h80000000, 2'd2, 1'b0, 33, {MI, G8, G3, G6, G4, G8}, 1'b1, "sdec_min");
        run(32'd0, 2'd1, 1'b1, 33, {BL, BL, BL, BL, BL, G0}, 1'b0, "udec_zero");

        // Second load pulse while busy must be dropped.
        @(negedge iCLK);
        iData = 32'd777; iMode = 2'd1; iBlank_lz = 1'b1; iLoad = 1'b1;
        @(negedge iCLK);
        iLoad = 1'b0;
        @(negedge iCLK);
        iData = 32'd999; iMode = 2'd0; iBlank_lz = 1'b0; iLoad = 1'b1;
        @(negedge iCLK);
        iLoad = 1'b0;
        dones = 0;
        repeat (50) begin
            @(negedge iCLK);
            if (oDone === 1'b1) dones++;
        end
        check("busy_dones", 64'(dones), 64'(1));
        check("busy_hex", 64'(oHEX), 64'({BL, BL, BL, G7, G7, G7}));
        check("busy_ovf", 64'(oOvf), 64'(0));

        // Reset in the middle of a conversion; make ovf non-zero first.
        run(32'd1234567, 2'd1, 1'b0, 33, {G2, G3, G4, G5, G6, G7}, 1'b1, "pre_abort");
        @(negedge iCLK);
        iData = 32'd123456; iMode = 2'd1; iBlank_lz = 1'b0; iLoad = 1'b1;
        @(negedge iCLK);
        iLoad = 1'b0;
        repeat (10) @(negedge iCLK);
        check("abort_busy_before", 64'(oBusy), 64'(1));
        iRST_n = 1'b0;
        #1;
        check("abort_hex", 64'(oHEX), 64'h3FF_FFFF_FFFF);
        check("abort_busy", 64'(oBusy), 64'(0));
        check("abort_done", 64'(oDone), 64'(0));
        check("abort_ovf", 64'(oOvf), 64'(0));
        @(negedge iCLK);
        iRST_n = 1'b1;
        dones = 0;
        repeat (40) begin
            @(negedge iCLK);
            if (oDone === 1'b1) dones++;
        end
        check("abort_no_done", 64'(dones), 64'(0));
        check("abort_hex_after", 64'(oHEX), 64'h3FF_FFFF_FFFF);

        run(32'd987654, 2'd1, 1'b0, 33, {G8 ^ 7'h10, G8, G7, G6, G5, G4}, 1'b0, "post_abort");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/display7_controller.md
# display7_controller

Parametrised seven-segment display controller for the RISC-V board output path. It captures a data word on a load strobe and renders it on N_DIGITS active-low seven-segment digits in one of three modes: hexadecimal, unsigned decimal or signed decimal. Decimal modes use a sequential shift-add-3 (double-dabble) binary-to-BCD converter. Leading-zero blanking and an overflow flag are provided. The display holds its previous image until the new one is committed, so it never shows a partial result.

## Interface
- N_DIGITS, 6: number of physical digits; must be at least 2.
- DATA_W, 32: width of the input word; must be at least 4.
- iCLK  in  1  system clock, rising edge.
- iRST_n  in  1  asynchronous active-low reset.
- iData  in  DATA_W  value to display; sampled on an accepted load.
- iLoad  in  1  load request; accepted only when oBusy=0.
- iMode  in  2  display mode, sampled with iData:
  - 0 = hex
  - 1 = unsigned decimal
  - 2 = signed decimal
  - 3 = treated as 0
- iBlank_lz  in  1  blank leading zeros; sampled with iData.
- oHEX  out  7*N_DIGITS  segments, active low. Digit k occupies [7k+6:7k]; bit 0 = segment a … bit 6 = segment g.
- oBusy  out  1  high while a load is being processed.
- oDone  out  1  one-cycle pulse after the new image is committed.
- oOvf  out  1  value did not fit in N_DIGITS; updated at commit.

## Operation
- The FSM has three states: IDLE, CONV and COMMIT.
- IDLE:
  - When iLoad=1, capture iData, iMode and iBlank_lz.
  - In decimal modes, clear the BCD register and the bit counter, then go to CONV.
  - In hex mode, go straight to COMMIT.
- Signed decimal mode:
  - If iData[DATA_W-1]=1, record a negative flag and convert the two's-complement magnitude.
  - The magnitude of the most negative value is 2^(DATA_W-1), treated as unsigned.
- CONV:
  - Each cycle, add 3 to every BCD digit that is ≥5, then shift the next data bit in, MSB first.
  - After exactly DATA_W shifts, go to COMMIT.
- BCD register: BCD_DIGITS = (DATA_W*3)/10 + 1 digits (10 for DATA_W=32).
- COMMIT: register the new oHEX and oOvf, pulse oDone, and return to IDLE.
- Digit sources:
  - Hex: digit k = nibble k of the data. Nibbles beyond DATA_W are zero-padded.
  - Unsigned decimal: digit k = BCD digit k.
  - Signed decimal and negative: digit N_DIGITS-1 shows minus (7'b0111111); the magnitude uses digits 0..N_DIGITS-2.
- Overflow: oOvf=1 if any non-zero source digit falls above the last usable digit. The display then shows the truncated low digits.
- Leading-zero blanking:
  - Zero digits above the most significant non-zero usable digit show blank (7'h7F).
  - Digit 0 is never blanked.
  - The minus sign is never blanked.
- Unused digit positions (no source digit) show blank.
- Glyphs: standard 0-9 and A-F (b and d in lower case).
- An iLoad while oBusy=1 is ignored; there is no queueing.

## Timing
- Reset values, applied asynchronously:
  - oHEX = all 7'h7F
  - oBusy = 0, oDone = 0, oOvf = 0
  - state = IDLE
- Load accepted at edge T.
- Hex mode:
  - oHEX and oOvf update at edge T+1.
  - oDone is high for the cycle following T+1.
- Decimal modes:
  - CONV spans edges T+1 … T+DATA_W.
  - oHEX and oOvf update at edge T+DATA_W+1.
  - oDone is high for the cycle following that edge.
- oBusy = (state ≠ IDLE). The next load is accepted at the earliest at edge T+2 (hex) or T+DATA_W+2 (decimal).
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Reset asserted during CONV or COMMIT aborts the operation immediately. The display goes blank and no oDone is produced.

## Structure
- Shared package `display7_pkg`:
  - mode encodings MODE_HEX, MODE_UDEC and MODE_SDEC
  - SEG_BLANK = 7'h7F and SEG_MINUS = 7'b0111111
  - the BCD_DIGITS formula
- Sub-module `seg7_glyph`: combinational 4-bit to 7-bit active-low glyph decoder, instantiated N_DIGITS times via generate.
- FSM, converter and blanking/overflow logic live in the top module.

## Test plan
All scenarios use N_DIGITS=6, DATA_W=32.
- Reset: hold iRST_n=0 → oHEX=42'h3FF_FFFF_FFFF (all blank), oBusy=0, oDone=0, oOvf=0. Repeat with iRST_n asserted mid-CONV → the same values, and no oDone pulse.
- Hex: iData=32'h00ABCDEF, iMode=0, iBlank_lz=0 → after 1 cycle the display reads "ABCDEF" (b/d lower-case glyphs), oOvf=0.
  - iData=32'h12345678 → "345678", oOvf=1.
- Unsigned decimal: iData=123456, iMode=1 → oBusy high for 33 cycles, oDone on cycle 34, display "123456", oOvf=0.
  - iData=1234567 → "234567", oOvf=1.
- Signed decimal: iData=32'hFFFF_FFD6 (-42), iMode=2, iBlank_lz=1 → display "-", blank, blank, blank, "4", "2".
  - iData=32'h8000_0000 → "-83648", oOvf=1.
- Blanking: iData=0, iMode=1, iBlank_lz=1 → digit 0 shows "0", digits 1-5 blank.
- Busy rule: pulse iLoad again two cycles after a decimal load → ignored; only the first value appears, with a single oDone.
